rr_arbiter_ctrl: RTL and testbench



---
 rtl/rr_arbiter_ctrl.sv | 88 ++++++++
 tb/tb_rr_arbiter_ctrl.sv | 119 +++++++++++
 2 files changed

// File: rtl/rr_arbiter_ctrl.sv
// rr_arbiter_ctrl: round-robin arbiter with a registered one-hot grant and one dead cycle between owners; ARB_TIMEOUT_EN adds a forced release after MAX_HOLD cycles.
module rr_arbiter_ctrl #(
  parameter int N_REQ    = 4,
  parameter int ID_W     = 2,
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid,
  output logic [ID_W-1:0]  gnt_id,
  output logic             expired
);
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
  state_t state, state_n;
  logic [N_REQ-1:0] gnt_n;
  logic [ID_W-1:0] id_n, last_ptr, ptr_n, win, idx;
  logic found, timeout;
  if (ID_W != $clog2(N_REQ) || MAX_HOLD < 2 || MAX_HOLD > 15 || CNT_W < $clog2(MAX_HOLD)) begin : g_param_err
    $error("rr_arbiter_ctrl: inconsistent parameters");
  end
  // Search upward from the slot after the last owner, so the last owner comes last.
  always_comb begin
    win = '0;
    found = 1'b0;
    idx = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = last_ptr + ID_W'(i);
      if (!found && req[idx]) begin
        win = idx;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_n = state;
    gnt_n = gnt;
    id_n = gnt_id;
    ptr_n = last_ptr;
    if (state == GRANT) begin
      if (!req[gnt_id] || timeout) begin
        state_n = GAP;
        gnt_n = '0;
      end
    end else begin
      state_n = found ? GRANT : IDLE;
      gnt_n = found ? N_REQ'(1) << win : '0;
      id_n = found ? win : gnt_id;
      ptr_n = found ? win : last_ptr;
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      gnt <= '0;
      gnt_id <= '0;
      last_ptr <= ID_W'(N_REQ-1);
    end else begin
      state <= state_n;
      gnt <= gnt_n;
      gnt_id <= id_n;
      last_ptr <= ptr_n;
    end
  assign gnt_valid = |gnt;
`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt, cnt_n;
  logic exp_n;
  assign timeout = hold_cnt == CNT_W'(MAX_HOLD-1) && |(req & ~gnt);
  // An owner dropping req on its timeout edge is a normal release, not an expiry.
  always_comb begin
    cnt_n = state != GRANT ? '0 : hold_cnt == CNT_W'(MAX_HOLD-1) ? hold_cnt : hold_cnt + 1'b1;
    exp_n = state == GRANT && req[gnt_id] && timeout;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      hold_cnt <= '0;
      expired <= 1'b0;
    end else begin
      hold_cnt <= cnt_n;
      expired <= exp_n;
    end
`else
  assign timeout = 1'b0;
  assign expired = 1'b0;
`endif
endmodule

// File: tb/tb_rr_arbiter_ctrl.sv
// tb_rr_arbiter_ctrl: scoreboard bench; a behavioural owner/queue model predicts each cycle and a monitor compares.
module tb_rr_arbiter_ctrl;
  localparam int N = 4, IW = 2, MH = 8;
  typedef struct packed {
    logic [N-1:0] g;
    logic v;
    logic [IW-1:0] id;
    logic e;
  } exp_t;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [N-1:0] req = '0, gnt, rnd;
  logic gnt_valid, expired;
  logic [IW-1:0] gnt_id;
  exp_t q[$];
  exp_t mon_e;
  int errors = 0, checks = 0;
  int owner = -1, last = N-1, held = 0, m_id = 0;
  bit m_exp = 1'b0;
  rr_arbiter_ctrl #(.N_REQ(N), .ID_W(IW), .MAX_HOLD(MH), .CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .gnt(gnt),
    .gnt_valid(gnt_valid), .gnt_id(gnt_id), .expired(expired)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // Owner-level model: who holds the resource, for how many cycles, and who went last.
  task automatic model_step();
    exp_t e;
    bit force_rel;
    force_rel = 1'b0;
    if (!reset_n) begin
      owner = -1; last = N-1; held = 0; m_id = 0; m_exp = 1'b0;
    end else if (owner >= 0) begin
      m_exp = 1'b0;
`ifdef ARB_TIMEOUT_EN
      force_rel = held >= MH && (req & ~(N'(1) << owner)) != '0;
`endif
      if (!req[owner]) owner = -1;
      else if (force_rel) begin
        owner = -1;
        m_exp = 1'b1;
      end else held++;
    end else begin
      m_exp = 1'b0;
      for (int k = 1; k <= N; k++)
        if (owner < 0 && req[(last+k)%N]) begin
          owner = (last+k)%N; last = owner; m_id = owner; held = 1;
        end
    end
    e.g = owner >= 0 ? N'(1) << owner : '0;
    e.v = owner >= 0;
    e.id = IW'(m_id);
    e.e = m_exp;
    q.push_back(e);
  endtask
  task automatic step(input bit rn, input logic [N-1:0] r);
    @(negedge clk);
    reset_n = rn;
    req = r;
    @(posedge clk);
    model_step();
  endtask
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk("gnt", int'(gnt), int'(mon_e.g));
      chk("gnt_valid", int'(gnt_valid), int'(mon_e.v));
      chk("gnt_id", int'(gnt_id), int'(mon_e.id));
      chk("expired", int'(expired), int'(mon_e.e));
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
  initial begin
    req = '1;
    #1;
    chk("reset_gnt", int'(gnt), 0);
    chk("reset_expired", int'(expired), 0);
    repeat (2) step(1'b0, 4'b1111);
    repeat (5) step(1'b1, 4'b0000);
    repeat (3) step(1'b1, 4'b0001);
    repeat (3) step(1'b1, 4'b0000);
    for (int c = 0; c < 20; c++)
      step(1'b1, (owner >= 0 && held >= 2) ? ~(N'(1) << owner) : 4'b1111);
    repeat (3) step(1'b1, 4'b0000);
    repeat (3) step(1'b1, 4'b0001);
    repeat (21) step(1'b1, 4'b0101);
    repeat (3) step(1'b1, 4'b0000);
    repeat (3) step(1'b1, 4'b0100);
    @(negedge clk);
    req = 4'b0100;
    #2 reset_n = 1'b0;
    #1;
    chk("async_gnt", int'(gnt), 0);
    chk("async_valid", int'(gnt_valid), 0);
    @(posedge clk);
    model_step();
    repeat (3) step(1'b1, 4'b0101);
    for (int c = 0; c < 600; c++) begin
      rnd = req ^ N'($urandom & $urandom);
      step($urandom_range(0, 99) != 0, rnd);
    end
    repeat (3) step(1'b1, 4'b0000);
    @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
